// File: rtl/gruel_pkg.sv
`default_nettype none
// ============================================================================
// Module : gruel_pkg
// Brief  : Shared state encoding and default pricing for the gruel vendor.
// Rev    : 1.0  initial release
// ============================================================================
package gruel_pkg;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        DISPENSE = 2'd1,
        REFUND   = 2'd2
    } vend_state_e;

    localparam int GRUEL_PRICE_DEFAULT      = 4;
    localparam int GRUEL_MAX_CREDIT_DEFAULT = 8;

endpackage
`default_nettype wire

// File: rtl/gruel_credit_acc.sv
`default_nettype none
// ============================================================================
// Module : gruel_credit_acc
// Brief  : Credit register with add/overflow-check, subtract, clear and reject flag.
// Rev    : 1.0  initial release
// ============================================================================
module gruel_credit_acc #(
    parameter int PRICE      = 4,
    parameter int MAX_CREDIT = 8,
    parameter int COIN_W     = 2,
    parameter int CREDIT_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                add_en,
    input  logic [COIN_W-1:0]   coin_value,
    input  logic                sub_en,
    input  logic                clr_en,
    output logic [CREDIT_W-1:0] credit,
    output logic [CREDIT_W-1:0] remainder,
    output logic                fits,
    output logic                reach_price,
    output logic                has_excess,
    output logic                reject
);

    // One spare bit above the wider operand, so the sum can never wrap.
    localparam int SUM_W = ((CREDIT_W > COIN_W) ? CREDIT_W : COIN_W) + 1;
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    logic [SUM_W-1:0] w_sum;

    assign w_sum       = SUM_W'(credit) + SUM_W'(coin_value);
    assign fits        = (w_sum <= SUM_W'(MAX_CREDIT));
    assign reach_price = (w_sum >= SUM_W'(PRICE));
    assign has_excess  = (credit > PRICE_C);
    assign remainder   = credit - PRICE_C;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credit <= '0;
            reject <= 1'b0;
        end else begin
            reject <= add_en && !fits;
            if (clr_en) begin
                credit <= '0;
            end else if (sub_en) begin
                credit <= remainder;
            end else if (add_en && fits) begin
                credit <= w_sum[CREDIT_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gruel_vend_ctrl.sv
`default_nettype none
// ============================================================================
// Module : gruel_vend_ctrl
// Brief  : Coin-collecting gruel vending controller with dispense and change.
//          Optional sales/reject counters enabled by GRUEL_SALES_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module gruel_vend_ctrl
    import gruel_pkg::*;
#(
    parameter  int PRICE      = GRUEL_PRICE_DEFAULT,
    parameter  int MAX_CREDIT = GRUEL_MAX_CREDIT_DEFAULT,
    parameter  int COIN_W     = 2,
    localparam int CREDIT_W   = $clog2(MAX_CREDIT + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [COIN_W-1:0]   coin_value,
    output logic                coin_ready,
    output logic                coin_reject,
    input  logic                cancel,
    output logic                dispense_valid,
    input  logic                dispense_ready,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amount,
    input  logic                change_ready,
`ifdef GRUEL_SALES_CNT_EN
    output logic [15:0]         sales_cnt,
    output logic [7:0]          reject_cnt,
`endif
    output logic [CREDIT_W-1:0] credit
);

    if ((PRICE < 1) || (PRICE > MAX_CREDIT)) begin : g_price_check
        $error("gruel_vend_ctrl: PRICE must lie in 1..MAX_CREDIT");
    end

    vend_state_e         r_state;
    logic                w_coin_fire;
    logic                w_disp_fire;
    logic                w_chg_fire;
    logic                w_fits;
    logic                w_reach_price;
    logic                w_has_excess;
    logic [CREDIT_W-1:0] w_remainder;

    assign coin_ready  = (r_state == COLLECT) && !cancel;
    assign w_coin_fire = coin_valid && coin_ready && (coin_value != '0);
    assign w_disp_fire = dispense_valid && dispense_ready;
    assign w_chg_fire  = change_valid && change_ready;

    gruel_credit_acc #(
        .PRICE      (PRICE),
        .MAX_CREDIT (MAX_CREDIT),
        .COIN_W     (COIN_W),
        .CREDIT_W   (CREDIT_W)
    ) u_acc (
        .clk         (clk),
        .rst_n       (rst_n),
        .add_en      (w_coin_fire),
        .coin_value  (coin_value),
        .sub_en      (w_disp_fire),
        .clr_en      (w_chg_fire),
        .credit      (credit),
        .remainder   (w_remainder),
        .fits        (w_fits),
        .reach_price (w_reach_price),
        .has_excess  (w_has_excess),
        .reject      (coin_reject)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= COLLECT;
            dispense_valid <= 1'b0;
            change_valid   <= 1'b0;
            change_amount  <= '0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (cancel && (credit != '0)) begin
                        r_state       <= REFUND;
                        change_valid  <= 1'b1;
                        change_amount <= credit;
                    end else if (w_coin_fire && w_fits && w_reach_price) begin
                        r_state        <= DISPENSE;
                        dispense_valid <= 1'b1;
                    end
                end
                DISPENSE: begin
                    if (dispense_ready) begin
                        dispense_valid <= 1'b0;
                        if (w_has_excess) begin
                            r_state       <= REFUND;
                            change_valid  <= 1'b1;
                            change_amount <= w_remainder;
                        end else begin
                            r_state <= COLLECT;
                        end
                    end
                end
                REFUND: begin
                    if (change_ready) begin
                        r_state       <= COLLECT;
                        change_valid  <= 1'b0;
                        change_amount <= '0;
                    end
                end
                default: begin
                    r_state        <= COLLECT;
                    dispense_valid <= 1'b0;
                    change_valid   <= 1'b0;
                    change_amount  <= '0;
                end
            endcase
        end
    end

`ifdef GRUEL_SALES_CNT_EN
    // Sales wrap naturally; rejects saturate so a jammed acceptor stays visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sales_cnt  <= '0;
            reject_cnt <= '0;
        end else begin
            if (w_disp_fire) begin
                sales_cnt <= sales_cnt + 16'd1;
            end
            if (coin_reject && (reject_cnt != 8'hFF)) begin
                reject_cnt <= reject_cnt + 8'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gruel_vend_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_gruel_vend_ctrl
// Brief  : Vector-table and sequence bench for gruel_vend_ctrl (PRICE 4 and 8).
// Rev    : 1.0  initial release
// ============================================================================
module tb_gruel_vend_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coin_valid;
    logic [1:0] coin_value;
    logic       cancel;
    logic       dispense_ready;
    logic       change_ready;

    logic       rdy_a, rej_a, dv_a, chv_a;
    logic [3:0] amt_a, cred_a;
    logic       rdy_b, rej_b, dv_b, chv_b;
    logic [3:0] amt_b, cred_b;
`ifdef GRUEL_SALES_CNT_EN
    logic [15:0] sales_a, sales_b;
    logic [7:0]  rejc_a, rejc_b;
`endif

    bit         sel;
    logic       o_rdy, o_rej, o_dv, o_chv;
    logic [3:0] o_amt, o_cred;

    assign o_rdy  = sel ? rdy_b  : rdy_a;
    assign o_rej  = sel ? rej_b  : rej_a;
    assign o_dv   = sel ? dv_b   : dv_a;
    assign o_chv  = sel ? chv_b  : chv_a;
    assign o_amt  = sel ? amt_b  : amt_a;
    assign o_cred = sel ? cred_b : cred_a;

    always #5 clk = ~clk;

    gruel_vend_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .coin_valid     (coin_valid),
        .coin_value     (coin_value),
        .coin_ready     (rdy_a),
        .coin_reject    (rej_a),
        .cancel         (cancel),
        .dispense_valid (dv_a),
        .dispense_ready (dispense_ready),
        .change_valid   (chv_a),
        .change_amount  (amt_a),
        .change_ready   (change_ready),
`ifdef GRUEL_SALES_CNT_EN
        .sales_cnt      (sales_a),
        .reject_cnt     (rejc_a),
`endif
        .credit         (cred_a)
    );

    gruel_vend_ctrl #(.PRICE(8)) dut8 (
        .clk            (clk),
        .rst_n          (rst_n),
        .coin_valid     (coin_valid),
        .coin_value     (coin_value),
        .coin_ready     (rdy_b),
        .coin_reject    (rej_b),
        .cancel         (cancel),
        .dispense_valid (dv_b),
        .dispense_ready (dispense_ready),
        .change_valid   (chv_b),
        .change_amount  (amt_b),
        .change_ready   (change_ready),
`ifdef GRUEL_SALES_CNT_EN
        .sales_cnt      (sales_b),
        .reject_cnt     (rejc_b),
`endif
        .credit         (cred_b)
    );

    typedef struct {
        bit         s, rn, cv;
        logic [1:0] val;
        bit         can, dr, cr, chk;
        bit         rdy, rej, dv, chv;
        logic [3:0] amt, cred;
    } vec_t;

    typedef struct {
        bit         rdy, rej, dv, chv;
        logic [3:0] amt, cred;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic void row(input bit s, rn, cv, input logic [1:0] val,
                                input bit can, dr, cr, chk, rdy, rej, dv, chv,
                                input logic [3:0] amt, cred);
        vec_t v;
        v.s = s; v.rn = rn; v.cv = cv; v.val = val; v.can = can; v.dr = dr;
        v.cr = cr; v.chk = chk; v.rdy = rdy; v.rej = rej; v.dv = dv; v.chv = chv;
        v.amt = amt; v.cred = cred;
        vecs.push_back(v);
    endfunction

    task automatic drive(input bit cv, input logic [1:0] val, input bit can, dr, cr);
        @(negedge clk);
        coin_valid = cv; coin_value = val; cancel = can;
        dispense_ready = dr; change_ready = cr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required to have finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   n;

        // Row fields: sel rst_n coin_valid value cancel d_ready c_ready chk | rdy rej dv chv amt credit
        row(0,1,1,1,0,0,0,1, 1,0,0,0,0,0);
        row(0,1,1,1,0,0,0,1, 1,0,0,0,0,1);
        row(0,1,1,2,0,0,0,1, 1,0,0,0,0,2);
        row(0,1,0,0,0,1,0,1, 0,0,1,0,0,4);
        row(0,1,0,0,0,0,0,1, 1,0,0,0,0,0);
        row(0,1,1,3,0,0,0,1, 1,0,0,0,0,0);
        row(0,1,1,3,0,0,0,1, 1,0,0,0,0,3);
        row(0,1,0,0,0,1,0,1, 0,0,1,0,0,6);
        row(0,1,0,0,0,0,0,1, 0,0,0,1,2,2);
        row(0,1,0,0,0,0,1,1, 0,0,0,1,2,2);
        row(0,1,0,0,0,0,0,1, 1,0,0,0,0,0);
        row(0,1,1,0,0,0,0,1, 1,0,0,0,0,0);
        row(0,1,1,2,0,0,0,1, 1,0,0,0,0,0);
        row(0,1,1,1,0,0,0,1, 1,0,0,0,0,2);
        row(0,1,1,1,1,0,0,1, 0,0,0,0,0,3);
        row(0,1,0,0,0,0,1,1, 0,0,0,1,3,3);
        row(0,1,0,0,1,0,0,1, 0,0,0,0,0,0);
        row(0,1,0,0,0,0,0,1, 1,0,0,0,0,0);
        row(0,1,1,2,0,0,0,1, 1,0,0,0,0,0);
        row(0,1,1,2,0,0,0,1, 1,0,0,0,0,2);
        for (int k = 0; k < 5; k++) row(0,1,1,1,1,0,0,1, 0,0,1,0,0,4);
        row(0,0,0,0,0,0,0,1, 0,0,1,0,0,4);
        row(0,1,0,0,0,0,0,1, 1,0,0,0,0,0);
        row(1,0,0,0,0,0,0,0, 0,0,0,0,0,0);
        row(1,1,1,3,0,0,0,1, 1,0,0,0,0,0);
        row(1,1,1,3,0,0,0,1, 1,0,0,0,0,3);
        row(1,1,1,1,0,0,0,1, 1,0,0,0,0,6);
        row(1,1,1,3,0,0,0,1, 1,0,0,0,0,7);
        row(1,1,0,0,0,0,0,1, 1,1,0,0,0,7);
        row(1,1,0,0,0,0,0,1, 1,0,0,0,0,7);
        row(1,1,1,1,0,0,0,1, 1,0,0,0,0,7);
        row(1,1,0,0,0,1,0,1, 0,0,1,0,0,8);
        row(1,1,0,0,0,0,0,1, 1,0,0,0,0,0);

        sel = 1'b0; rst_n = 1'b0; coin_valid = 1'b0; coin_value = 2'd0;
        cancel = 1'b0; dispense_ready = 1'b0; change_ready = 1'b0;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            sel = vecs[i].s; rst_n = vecs[i].rn; coin_valid = vecs[i].cv;
            coin_value = vecs[i].val; cancel = vecs[i].can;
            dispense_ready = vecs[i].dr; change_ready = vecs[i].cr;
            if (vecs[i].chk)
                exp_q.push_back('{vecs[i].rdy, vecs[i].rej, vecs[i].dv,
                                  vecs[i].chv, vecs[i].amt, vecs[i].cred});
            #1;
            if (vecs[i].chk) begin
                e = exp_q.pop_front();
                check($sformatf("row%0d.coin_ready", i),     o_rdy,  e.rdy);
                check($sformatf("row%0d.coin_reject", i),    o_rej,  e.rej);
                check($sformatf("row%0d.dispense_valid", i), o_dv,   e.dv);
                check($sformatf("row%0d.change_valid", i),   o_chv,  e.chv);
                check($sformatf("row%0d.change_amount", i),  o_amt,  e.amt);
                check($sformatf("row%0d.credit", i),         o_cred, e.cred);
                check($sformatf("row%0d.exclusive", i),      o_dv & o_chv, 1'b0);
            end
        end

        // Three vends at PRICE 8, the first two preceded by an overflowing coin.
        sel = 1'b1;
        @(negedge clk);
        rst_n = 1'b0; coin_valid = 1'b0; cancel = 1'b0;
        dispense_ready = 1'b0; change_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("seq.reset_credit", o_cred, 4'd0);
        check("seq.reset_dispense", o_dv, 1'b0);
        for (int v = 0; v < 3; v++) begin
            drive(1, 2'd3, 0, 0, 0);
            drive(1, 2'd3, 0, 0, 0);
            drive(1, 2'd1, 0, 0, 0);
            if (v < 2) drive(1, 2'd3, 0, 0, 0);
            drive(1, 2'd1, 0, 0, 0);
            #1;
            if (v < 2) check($sformatf("seq%0d.reject_pulse", v), o_rej, 1'b1);
            check($sformatf("seq%0d.credit_before_full", v), o_cred, 4'd7);
            @(negedge clk);
            coin_valid = 1'b0; dispense_ready = 1'b1;
            #1;
            n = 0;
            while (!o_dv && n < 8) begin
                @(negedge clk);
                #1;
                n++;
            end
            check($sformatf("seq%0d.vend_valid", v), o_dv, 1'b1);
            check($sformatf("seq%0d.vend_credit", v), o_cred, 4'd8);
            @(negedge clk);
            dispense_ready = 1'b0;
            #1;
            check($sformatf("seq%0d.after_vend_dv", v), o_dv, 1'b0);
            check($sformatf("seq%0d.after_vend_credit", v), o_cred, 4'd0);
            check($sformatf("seq%0d.after_vend_chv", v), o_chv, 1'b0);
        end
`ifdef GRUEL_SALES_CNT_EN
        repeat (2) @(negedge clk);
        #1;
        check("cnt.sales", sales_b, 16'd3);
        check("cnt.reject", rejc_b, 8'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
